fetch_sequencer: RTL and testbench

Owns the architectural PC and sequences instruction fetch for the WISC-15 pipeline. It issues requests to instruction memory over a req/rdy handshake and presents fetched words to the IF/ID register. It also applies redirects from the branch/call/return resolution logic, honours hazard stalls and stops fetch on HLT. It sits between instruction memory, the hazard unit and the next-PC resolution logic.

---
 rtl/wisc_fetch_pkg.sv | 14 +
 rtl/fetch_hold_buf.sv | 37 +++
 rtl/fetch_sequencer.sv | 128 ++++++++++++
 tb/tb_fetch_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_fetch_pkg.sv
// rtl/wisc_fetch_pkg.sv - shared widths, reset PC and FSM state type for instruction fetch
package wisc_fetch_pkg;
    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_FETCH,
        ST_HOLD,
        ST_DRAIN,
        ST_HALTED
    } fetch_state_t;
endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - one-entry {valid, word, pc} buffer for a word fetched during a stall
module fetch_hold_buf
    import wisc_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_consume,
    input  logic              i_clear,
    input  logic [WORD_W-1:0] i_word,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_word,
    output logic [ADDR_W-1:0] o_pc
);
    logic              r_valid;
    logic [WORD_W-1:0] r_word;
    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_word  <= '0;
            r_pc    <= '0;
        end else if (i_clear || i_consume) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_word  <= i_word;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_word  = r_word;
    assign o_pc    = r_pc;
endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and instruction-fetch sequencer with stall, redirect and halt
module fetch_sequencer
    import wisc_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_pc,
    input  logic              halt_i,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rdy,
    input  logic [WORD_W-1:0] imem_data,
    output logic              instr_valid,
    output logic [WORD_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              if_id_flush,
    output logic              halted
);
    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_halt_pend;
    logic              w_halt_pend_next;
    logic              w_redir;
    logic              w_halt;
    logic              w_outstanding;
    logic              w_fetch_take;
    logic              w_fetch_hold;
    logic              w_hold_take;
    logic              w_buf_valid;
    logic [WORD_W-1:0] w_buf_word;
    logic [ADDR_W-1:0] w_buf_pc;

    // BOOT never accepts a halt so that it always proceeds to FETCH.
    assign w_redir       = redir_valid && (r_state != ST_HALTED);
    assign w_halt        = halt_i && !stall_i && !redir_valid &&
                           (r_state != ST_HALTED) && (r_state != ST_BOOT);
    assign w_outstanding = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
    assign w_fetch_take  = (r_state == ST_FETCH) && imem_rdy && !stall_i && !w_redir && !w_halt;
    assign w_fetch_hold  = (r_state == ST_FETCH) && imem_rdy && stall_i && !w_redir;
    assign w_hold_take   = (r_state == ST_HOLD) && !stall_i && !w_redir && !w_halt;

    assign w_halt_pend_next = w_redir ? 1'b0 : (r_halt_pend || w_halt);
    assign w_pc_next = w_redir ? redir_pc :
                       (w_fetch_take || w_hold_take) ? r_pc + 16'd1 : r_pc;

    fetch_hold_buf u_hold_buf (
        .clk       (clk),
        .i_rst     (rst),
        .i_load    (w_fetch_hold),
        .i_consume (w_hold_take),
        .i_clear   (w_redir || w_halt),
        .i_word    (imem_data),
        .i_pc      (r_pc),
        .o_valid   (w_buf_valid),
        .o_word    (w_buf_word),
        .o_pc      (w_buf_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_BOOT;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BOOT:  w_state_next = ST_FETCH;
            ST_FETCH: begin
                if (w_redir)                  w_state_next = imem_rdy ? ST_FETCH : ST_DRAIN;
                else if (w_halt)              w_state_next = imem_rdy ? ST_HALTED : ST_DRAIN;
                else if (imem_rdy && stall_i) w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (w_redir)       w_state_next = ST_FETCH;
                else if (w_halt)   w_state_next = ST_HALTED;
                else if (!stall_i) w_state_next = ST_FETCH;
            end
            ST_DRAIN: begin
                if (imem_rdy) w_state_next = w_halt_pend_next ? ST_HALTED : ST_FETCH;
            end
            ST_HALTED: w_state_next = ST_HALTED;
            default:   w_state_next = ST_BOOT;
        endcase
    end

    always_comb begin
        instr_valid = 1'b0;
        instr       = '0;
        instr_pc    = '0;
        if (!w_redir && !w_halt) begin
            if ((r_state == ST_FETCH) && imem_rdy && !stall_i) begin
                instr_valid = 1'b1;
                instr       = imem_data;
                instr_pc    = r_pc;
            end else if ((r_state == ST_HOLD) && w_buf_valid) begin
                instr_valid = 1'b1;
                instr       = w_buf_word;
                instr_pc    = w_buf_pc;
            end
        end
        imem_req    = w_outstanding;
        if_id_flush = w_redir;
        halted      = (r_state == ST_HALTED);
    end

    // req_addr reloads only when a fresh request starts, so an in-flight address never moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_req_addr  <= '0;
            r_halt_pend <= 1'b0;
        end else begin
            r_pc        <= w_pc_next;
            r_halt_pend <= w_halt_pend_next;
            if ((w_state_next == ST_FETCH) && !((r_state == ST_FETCH) && !imem_rdy))
                r_req_addr <= w_pc_next;
        end
    end

    assign imem_addr = r_req_addr;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        redir_valid = 1'b0;
    logic [15:0] redir_pc = 16'h0;
    logic        halt_i = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy = 1'b0;
    logic [15:0] imem_data = 16'h0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        if_id_flush;
    logic        halted;

    typedef struct packed {
        logic [15:0] word;
        logic [15:0] pc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    fetch_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall_i),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .halt_i      (halt_i),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdy    (imem_rdy),
        .imem_data   (imem_data),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .if_id_flush (if_id_flush),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Every instruction accepted by IF/ID is matched against the scoreboard.
    always @(negedge clk) begin
        #2;
        if (!rst && instr_valid && !stall_i) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: instr=%h pc=%h required no instruction", instr, instr_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (instr !== e.word || instr_pc !== e.pc) begin
                    failures++;
                    $display("FAIL sb_instr: instr=%h pc=%h required instr=%h pc=%h", instr, instr_pc, e.word, e.pc);
                end
            end
        end
        if (!rst && halted) begin
            checks++;
            if (if_id_flush !== 1'b0) begin
                failures++;
                $display("FAIL flush_in_halted: if_id_flush=%b required 0", if_id_flush);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stall_i = 1'b0; redir_valid = 1'b0; halt_i = 1'b0;
        imem_rdy = 1'b0; imem_data = 16'h0; redir_pc = 16'h0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || if_id_flush !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: req=%b valid=%b flush=%b halted=%b required all 0",
                     imem_req, instr_valid, if_id_flush, halted);
        end
        checks++;
        if (instr !== 16'h0 || instr_pc !== 16'h0 || imem_addr !== 16'h0) begin
            failures++;
            $display("FAIL reset_data: instr=%h instr_pc=%h addr=%h required 0", instr, instr_pc, imem_addr);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL boot_no_req: imem_req=%b required 0", imem_req);
        end
    endtask

    task automatic zero_wait_fetch(input logic [15:0] addr);
        @(negedge clk);
        imem_rdy = 1'b1; imem_data = addr + 16'h1000; stall_i = 1'b0;
        sb.push_back('{word: addr + 16'h1000, pc: addr});
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== addr) begin
            failures++;
            $display("FAIL fetch_req: req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, addr);
        end
    endtask

    task automatic idle_check_req(input string name, input logic [15:0] addr);
        @(negedge clk);
        imem_rdy = 1'b0; stall_i = 1'b0; redir_valid = 1'b0; halt_i = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== addr) begin
            failures++;
            $display("FAIL %s: req=%b addr=%h required req=1 addr=%h", name, imem_req, imem_addr, addr);
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_fetch();
        for (int i = 0; i < 3; i++) begin
            zero_wait_fetch(16'(i));
            checks++;
            if (halted !== 1'b0) begin
                failures++;
                $display("FAIL fetch_halted: halted=%b required 0", halted);
            end
        end
        idle_check_req("fetch_next", 16'h0003);
    endtask

    task automatic test_stall();
        zero_wait_fetch(16'h0003);
        zero_wait_fetch(16'h0004);
        @(negedge clk);
        imem_rdy = 1'b1; imem_data = 16'h1005; stall_i = 1'b1;
        #1;
        checks++;
        if (imem_addr !== 16'h0005 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_capture: addr=%h valid=%b required addr=0005 valid=0", imem_addr, instr_valid);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            imem_rdy = 1'b0; imem_data = 16'hdead; stall_i = 1'b1;
            #1;
            checks++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr !== 16'h1005 || instr_pc !== 16'h0005) begin
                failures++;
                $display("FAIL hold: req=%b valid=%b instr=%h pc=%h required 0 1 1005 0005",
                         imem_req, instr_valid, instr, instr_pc);
            end
        end
        @(negedge clk);
        stall_i = 1'b0;
        sb.push_back('{word: 16'h1005, pc: 16'h0005});
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL hold_release_req: req=%b required 0", imem_req);
        end
        idle_check_req("after_hold", 16'h0006);
    endtask

    task automatic test_redirect();
        zero_wait_fetch(16'h0006);
        @(negedge clk);
        imem_rdy = 1'b0; redir_valid = 1'b1; redir_pc = 16'h0040;
        #1;
        checks++;
        if (if_id_flush !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 16'h0007) begin
            failures++;
            $display("FAIL redir_flush: flush=%b valid=%b addr=%h required 1 0 0007",
                     if_id_flush, instr_valid, imem_addr);
        end
        @(negedge clk);
        redir_valid = 1'b0;
        #1;
        checks++;
        if (if_id_flush !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0007) begin
            failures++;
            $display("FAIL drain_hold: flush=%b req=%b addr=%h required 0 1 0007", if_id_flush, imem_req, imem_addr);
        end
        @(negedge clk);
        imem_rdy = 1'b1; imem_data = 16'h1007;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 16'h0007) begin
            failures++;
            $display("FAIL drain_drop: valid=%b addr=%h required 0 0007", instr_valid, imem_addr);
        end
        idle_check_req("redir_target", 16'h0040);
        zero_wait_fetch(16'h0040);
    endtask

    task automatic test_halt_redirect();
        @(negedge clk);
        imem_rdy = 1'b1; imem_data = 16'h1041; halt_i = 1'b1; redir_valid = 1'b1; redir_pc = 16'h0020;
        #1;
        checks++;
        if (if_id_flush !== 1'b1 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL halt_redir_flush: flush=%b valid=%b required 1 0", if_id_flush, instr_valid);
        end
        idle_check_req("halt_redir_target", 16'h0020);
        checks++;
        if (halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_redir_halted: halted=%b required 0", halted);
        end
        zero_wait_fetch(16'h0020);
    endtask

    task automatic test_halt_drain();
        @(negedge clk);
        imem_rdy = 1'b0; halt_i = 1'b1;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || halted !== 1'b0 || if_id_flush !== 1'b0) begin
            failures++;
            $display("FAIL halt_accept: valid=%b halted=%b flush=%b required 0 0 0", instr_valid, halted, if_id_flush);
        end
        idle_check_req("halt_drain1", 16'h0021);
        idle_check_req("halt_drain2", 16'h0021);
        @(negedge clk);
        imem_rdy = 1'b1; imem_data = 16'h1021;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_drop: valid=%b halted=%b required 0 0", instr_valid, halted);
        end
        @(negedge clk);
        imem_rdy = 1'b0; redir_valid = 1'b1; redir_pc = 16'h0099;
        #1;
        checks++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || if_id_flush !== 1'b0) begin
            failures++;
            $display("FAIL halted_state: halted=%b req=%b flush=%b required 1 0 0", halted, imem_req, if_id_flush);
        end
        @(negedge clk);
        redir_valid = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b1 || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL halted_sticky: halted=%b req=%b required 1 0", halted, imem_req);
        end
        do_reset();
        idle_check_req("restart_pc", 16'h0000);
    endtask

    task automatic test_wrap();
        @(negedge clk);
        imem_rdy = 1'b1; imem_data = 16'h1000; redir_valid = 1'b1; redir_pc = 16'hffff;
        @(negedge clk);
        redir_valid = 1'b0; imem_rdy = 1'b0;
        zero_wait_fetch(16'hffff);
        idle_check_req("wrap", 16'h0000);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_halt_redirect();
        test_halt_drain();
        test_wrap();
        @(negedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: pending=%0d required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
